// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one edge-strobed memory between two requesters via setup/strobe/capture accesses
module mem_port_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 8,
   parameter int FIX_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
   localparam bit RR = (FIX_PRIORITY == 0);
   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              pick1;

   assign pick1       = req1 && (!req0 || (RR && !last_q));
   assign busy        = state_q != IDLE;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_read    = state_q == STROBE && !we_q;
   assign mem_write   = state_q == STROBE && we_q;
   assign done0       = state_q == DONE && !gnt_q;
   assign done1       = state_q == DONE && gnt_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;

   // Next state: grant and latch request in IDLE, walk the access sequence, capture read data leaving DONE
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      unique case (state_q)
         IDLE: if (req0 || req1) begin
            state_d = SETUP;
            gnt_d   = pick1;
            last_d  = pick1;
            we_d    = pick1 ? we1 : we0;
            addr_d  = pick1 ? addr1 : addr0;
            wdata_d = pick1 ? wdata1 : wdata0;
         end
         SETUP:  state_d = STROBE;
         STROBE: state_d = DONE;
         default: begin
            state_d  = IDLE;
            rdata0_d = (!we_q && !gnt_q) ? mem_rdata : rdata0_q;
            rdata1_d = (!we_q && gnt_q) ? mem_rdata : rdata1_q;
         end
      endcase
   end

   // State and latched-request registers; reset abandons any in-flight access
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the two-port memory arbiter
module tb_mem_port_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [4:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       done0, done1, busy, mem_read, mem_write;
   logic [7:0] rdata0, rdata1, mem_wdata;
   logic [4:0] mem_address;
   logic [7:0] mem_rdata = '0;
   logic       done0_f, done1_f, busy_f, mem_read_f, mem_write_f;
   logic [7:0] rdata0_f, rdata1_f, mem_wdata_f;
   logic [4:0] mem_address_f;
   logic [7:0] mem_rdata_f = '0;
   logic [7:0] wr_mem [32];
   logic [31:0] wr_valid = '0;
   int checks = 0;
   int passed = 0;

   typedef struct {
      int         port;
      logic [7:0] data;
   } exp_t;
   exp_t sbq[$];

   mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIX_PRIORITY(0)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .rdata1(rdata1),
      .busy(busy), .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(5), .DATA_W(8), .FIX_PRIORITY(1)) u_fp (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0_f), .rdata0(rdata0_f),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1_f), .rdata1(rdata1_f),
      .busy(busy_f), .mem_address(mem_address_f), .mem_wdata(mem_wdata_f),
      .mem_read(mem_read_f), .mem_write(mem_write_f), .mem_rdata(mem_rdata_f)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      return (i == 0) ? 8'h99 : 8'(i * 37 + 11);
   endfunction

   // Edge-strobed memory models
   always @(posedge mem_write) begin
      wr_mem[mem_address]   <= mem_wdata;
      wr_valid[mem_address] <= 1'b1;
   end
   always @(posedge mem_read)
      mem_rdata <= wr_valid[mem_address] ? wr_mem[mem_address] : init_val(int'(mem_address));
   always @(posedge mem_read_f)
      mem_rdata_f <= init_val(int'(mem_address_f));

   // Strobe and done exclusivity watch
   always @(negedge clk)
      if ((mem_read && mem_write) || (done0 && done1)) begin
         checks++;
         $display("FAIL exclusivity: rd=%b wr=%b done0=%b done1=%b required never both", mem_read, mem_write, done0, done1);
      end

   task automatic wait_done(output int port, output int port_f, output logic [7:0] rd,
                            output int nstb, output logic [4:0] saddr, output int cyc);
      port = -1; port_f = -1; rd = '0; nstb = 0; saddr = '0; cyc = 0;
      for (int i = 0; i < 16 && port < 0; i++) begin
         @(negedge clk);
         cyc++;
         if (mem_read || mem_write) begin
            nstb++;
            saddr = mem_address;
         end
         if (done0 || done1) begin
            port   = done1 ? 1 : 0;
            port_f = done1_f ? 1 : (done0_f ? 0 : -1);
         end
      end
      if (port >= 0) begin
         @(negedge clk);
         rd = (port == 1) ? rdata1 : rdata0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if ({done0, done1} !== 2'b00) $display("FAIL reset_done: got %b want 00", {done0, done1}); else passed++;
      checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_strobe: got %b want 00", {mem_read, mem_write}); else passed++;
      checks++; if (rdata0 !== 8'h00) $display("FAIL reset_rdata0: got %h want 00", rdata0); else passed++;
      checks++; if (rdata1 !== 8'h00) $display("FAIL reset_rdata1: got %h want 00", rdata1); else passed++;
      checks++; if (mem_address !== 5'd0) $display("FAIL reset_addr: got %0d want 0", mem_address); else passed++;
   endtask

   task automatic test_read_latency;
      exp_t e;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
      sbq.push_back('{0, 8'h99});
      @(negedge clk);
      checks++; if ({busy, mem_read} !== 2'b10) $display("FAIL lat_setup: busy,rd got %b want 10", {busy, mem_read}); else passed++;
      @(negedge clk);
      checks++; if ({mem_read, mem_write} !== 2'b10) $display("FAIL lat_strobe: rd,wr got %b want 10", {mem_read, mem_write}); else passed++;
      @(negedge clk);
      checks++; if ({done0, done1, mem_read} !== 3'b100) $display("FAIL lat_done: d0,d1,rd got %b want 100", {done0, done1, mem_read}); else passed++;
      req0 = 1'b0;
      @(negedge clk);
      e = sbq.pop_front();
      checks++; if (rdata0 !== e.data) $display("FAIL lat_rdata0: got %h want %h", rdata0, e.data); else passed++;
      checks++; if ({busy, done0} !== 2'b00) $display("FAIL lat_idle: busy,d0 got %b want 00", {busy, done0}); else passed++;
   endtask

   task automatic test_write_read;
      exp_t e;
      int p, pf, ns, cy;
      logic [7:0] rd;
      logic [4:0] sa;
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd5; wdata1 = 8'hA5;
      sbq.push_back('{1, 8'h00});
      wait_done(p, pf, rd, ns, sa, cy);
      req1 = 1'b0;
      e = sbq.pop_front();
      checks++; if (p !== e.port) $display("FAIL wr_port: got %0d want %0d", p, e.port); else passed++;
      checks++; if (ns !== 1) $display("FAIL wr_strobes: got %0d want 1", ns); else passed++;
      checks++; if (rd !== e.data) $display("FAIL wr_rdata1_kept: got %h want %h", rd, e.data); else passed++;
      checks++; if (wr_mem[5] !== 8'hA5) $display("FAIL wr_mem5: got %h want a5", wr_mem[5]); else passed++;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
      sbq.push_back('{1, 8'hA5});
      wait_done(p, pf, rd, ns, sa, cy);
      req1 = 1'b0;
      e = sbq.pop_front();
      checks++; if (p !== e.port) $display("FAIL rd5_port: got %0d want %0d", p, e.port); else passed++;
      checks++; if (rd !== e.data) $display("FAIL rd5_rdata1: got %h want %h", rd, e.data); else passed++;
   endtask

   task automatic test_arbitration;
      exp_t e;
      int p, pf, ns, cy;
      logic [7:0] rd;
      logic [4:0] sa;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
      for (int k = 0; k < 4; k++) begin
         sbq.push_back('{k % 2, init_val(1 + k % 2)});
         wait_done(p, pf, rd, ns, sa, cy);
         e = sbq.pop_front();
         checks++; if (p !== e.port) $display("FAIL rr_port[%0d]: got %0d want %0d", k, p, e.port); else passed++;
         checks++; if (rd !== e.data) $display("FAIL rr_rdata[%0d]: got %h want %h", k, rd, e.data); else passed++;
         checks++; if (pf !== 0) $display("FAIL fix_port[%0d]: got %0d want 0", k, pf); else passed++;
         if (k > 0) begin
            checks++; if (cy + 1 !== 4) $display("FAIL rr_gap[%0d]: got %0d want 4", k, cy + 1); else passed++;
         end
      end
      req0 = 1'b0;
      sbq.push_back('{1, init_val(2)});
      wait_done(p, pf, rd, ns, sa, cy);
      req1 = 1'b0;
      e = sbq.pop_front();
      checks++; if (p !== e.port) $display("FAIL solo1_port: got %0d want %0d", p, e.port); else passed++;
      checks++; if (pf !== 1) $display("FAIL fix_solo1_port: got %0d want 1", pf); else passed++;
      checks++; if (rd !== e.data) $display("FAIL solo1_rdata: got %h want %h", rd, e.data); else passed++;
   endtask

   task automatic test_addr_latch;
      exp_t e;
      int p, pf, ns, cy;
      logic [7:0] rd;
      logic [4:0] sa;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
      sbq.push_back('{0, init_val(3)});
      @(negedge clk);
      addr0 = 5'd7;
      wait_done(p, pf, rd, ns, sa, cy);
      req0 = 1'b0;
      e = sbq.pop_front();
      checks++; if (p !== e.port) $display("FAIL latch_port: got %0d want %0d", p, e.port); else passed++;
      checks++; if (sa !== 5'd3) $display("FAIL latch_addr: got %0d want 3", sa); else passed++;
      checks++; if (rd !== e.data) $display("FAIL latch_rdata0: got %h want %h", rd, e.data); else passed++;
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int p, pf, ns, cy, nd;
      logic [7:0] rd;
      logic [4:0] sa;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_read !== 1'b1) $display("FAIL mid_strobe: got %b want 1", mem_read); else passed++;
      #1 rst = 1'b1;
      #1;
      checks++; if ({mem_read, mem_write, busy} !== 3'b000) $display("FAIL mid_async: rd,wr,busy got %b want 000", {mem_read, mem_write, busy}); else passed++;
      req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (6) begin
         @(negedge clk);
         if (done0 || done1) nd++;
      end
      checks++; if (nd !== 0) $display("FAIL mid_no_done: got %0d dones want 0", nd); else passed++;
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
      sbq.push_back('{0, 8'h99});
      wait_done(p, pf, rd, ns, sa, cy);
      req0 = 1'b0;
      e = sbq.pop_front();
      checks++; if (p !== e.port) $display("FAIL mid_next_port: got %0d want %0d", p, e.port); else passed++;
      checks++; if (rd !== e.data) $display("FAIL mid_next_rdata: got %h want %h", rd, e.data); else passed++;
   endtask

   initial begin
      test_reset();
      test_read_latency();
      test_write_read();
      test_arbitration();
      test_addr_latch();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
